// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller between the data bus and the
// UART bit-level core. Decodes the TXD/RXD/CON register window, queues
// outgoing bytes, sequences the core's transmitter and latches received bytes.
// Optional feature: define UART_CTRL_IRQ_EN to add the registered irq output.

module uart_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          TXQ_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
`ifdef UART_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int          PTR_W      = $clog2(TXQ_DEPTH);
    localparam logic [31:0] RXD_ADDR   = BASE_ADDR + 32'd4;
    localparam logic [31:0] CON_ADDR   = BASE_ADDR + 32'd8;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(TXQ_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       txq_mem [TXQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             tx_en;
    logic             rx_en;
    logic             tx_done_st;
    logic             rx_ready;
    logic [7:0]       rxbuf;

    // Word-aligned decode: the byte offset within a word is don't-care.
    logic sel_txd, sel_rxd, sel_con;
    assign sel_txd = (addr[31:2] == BASE_ADDR[31:2]);
    assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign sel_con = (addr[31:2] == CON_ADDR[31:2]);

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    logic q_empty, q_full, push, pop, rd_rxd, tx_busy_st;
    assign q_empty    = (count == '0);
    assign q_full     = (count == FULL_COUNT);
    assign push       = wr && sel_txd && !q_full;
    assign pop        = (state == ST_START);
    assign rd_rxd     = rd && sel_rxd;
    assign tx_busy_st = !q_empty || (state != ST_IDLE) || tx_busy;

    // The core sees the queue head only during the single START cycle.
    assign tx_start = (state == ST_START);
    assign tx_data  = tx_start ? txq_mem[rd_ptr] : 8'h00;

    // Combinational register read mux.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rdata = 32'h0;
        if (sel_rxd)
            rdata = {24'h0, rxbuf};
        else if (sel_con)
            rdata = {27'h0, tx_busy_st, rx_ready, tx_done_st, rx_en, tx_en};
    end

    // TX FSM next-state: a started byte always runs to tx_done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tx_en && !q_empty && !tx_busy) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (tx_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // TX FSM state register.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Queue storage; pointers and count carry validity, so the array needs no reset.
    always_ff @(posedge sysclk) begin
        // NOTE: memory arrays are deliberately left unreset so they map onto plain RAM/registers without a reset tree.
        if (push) txq_mem[wr_ptr] <= wdata[7:0];
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Control bits and sticky TX status; a done set beats a CON clear-on-read.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            tx_done_st <= 1'b0;
        end else begin
            if (wr && sel_con) begin
                tx_en <= wdata[0];
                rx_en <= wdata[1];
            end
            if (state == ST_WAIT && tx_done)
                tx_done_st <= 1'b1;
            else if (rd && sel_con)
                tx_done_st <= 1'b0;
        end
    end

    // Receive buffer: a byte lands if the buffer is free or is being read this cycle.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxbuf    <= 8'h00;
            rx_ready <= 1'b0;
        end else if (rx_valid && rx_en && (!rx_ready || rd_rxd)) begin
            rxbuf    <= rx_data;
            rx_ready <= 1'b1;
        end else if (rd_rxd) begin
            rx_ready <= 1'b0;
        end
    end

`ifdef UART_CTRL_IRQ_EN
    // Registered level interrupt, one cycle behind the status bits.
    always_ff @(posedge sysclk) begin
        if (reset) irq <= 1'b0;
        else       irq <= (rx_ready & rx_en) | (tx_done_st & tx_en);
    end
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl. Register-access vectors
// come from a table; transmitted bytes go through a scoreboard queue that a
// monitor drains on every tx_start. A small core model answers tx_start with
// busy and a tx_done pulse. Define UART_CTRL_IRQ_EN to also check irq.

module tb_uart_ctrl;

    localparam logic [31:0] A_TXD  = 32'h40000018;
    localparam logic [31:0] A_RXD  = 32'h4000001C;
    localparam logic [31:0] A_CON  = 32'h40000020;
    localparam logic [31:0] A_NONE = 32'h40000024;
    localparam int          DEPTH  = 4;
    localparam int          CORE_LEN = 20;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] addr   = 32'h0;
    logic        wr     = 1'b0;
    logic        rd     = 1'b0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
`ifdef UART_CTRL_IRQ_EN
    logic        irq;
`endif

    logic core_busy = 1'b0;
    logic core_done = 1'b0;
    logic hold_busy = 1'b0;
    logic start_seen = 1'b0;
    logic prev_start = 1'b0;
    int   core_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_starts = 0;
    logic [7:0] exp_q [$];

    assign tx_busy = core_busy | hold_busy;
    assign tx_done = core_done;

    always #5 sysclk = ~sysclk;

    uart_ctrl #(.BASE_ADDR(A_TXD), .TXQ_DEPTH(DEPTH)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .addr     (addr),
        .wr       (wr),
        .rd       (rd),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef UART_CTRL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    typedef struct {
        string       name;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          chk;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        #1;
        check(name, rdata, exp);
        tick();
        rd = 1'b0;
    endtask

    task automatic peek_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_con(input string name, input logic [31:0] mask,
                            input logic [31:0] val, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            addr = A_CON; rd = 1'b0;
            #1;
            if ((rdata & mask) == val) found = 1'b1;
            else tick();
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Scoreboard monitor: every tx_start must match the oldest expected byte.
    always @(negedge sysclk) begin
        if (tx_start) begin
            n_starts++;
            start_seen = 1'b1;
            check("tx_start_single_cycle", 32'(prev_start), 32'd0);
            check("tx_start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        prev_start = tx_start;
    end

    // Core model: busy for CORE_LEN cycles after a tx_start, then a one-cycle tx_done.
    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            core_done = 1'b0;
            if (core_cnt != 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done = 1'b1;
                    core_busy = 1'b0;
                end
            end
            if (start_seen) begin
                start_seen = 1'b0;
                core_busy  = 1'b1;
                core_cnt   = CORE_LEN;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ;
        int starts_before;

        vec[0]  = '{"con_after_reset", 1'b0, 1'b1, A_CON,      32'h0,        32'h0, 1'b1};
        vec[1]  = '{"con_write_3",     1'b1, 1'b0, A_CON,      32'h3,        32'h0, 1'b0};
        vec[2]  = '{"con_read_3",      1'b0, 1'b1, A_CON,      32'h0,        32'h3, 1'b1};
        vec[3]  = '{"txd_reads_0",     1'b0, 1'b1, A_TXD,      32'h0,        32'h0, 1'b1};
        vec[4]  = '{"rxd_reset_0",     1'b0, 1'b1, A_RXD,      32'h0,        32'h0, 1'b1};
        vec[5]  = '{"unmapped_0",      1'b0, 1'b1, A_NONE,     32'h0,        32'h0, 1'b1};
        vec[6]  = '{"con_byte_off",    1'b0, 1'b1, A_CON + 3,  32'h0,        32'h3, 1'b1};
        vec[7]  = '{"con_write_hi",    1'b1, 1'b0, A_CON,      32'hFFFFFFFE, 32'h0, 1'b0};
        vec[8]  = '{"con_only_low2",   1'b0, 1'b1, A_CON,      32'h0,        32'h2, 1'b1};
        vec[9]  = '{"con_write_0",     1'b1, 1'b0, A_CON,      32'h0,        32'h0, 1'b0};
        vec[10] = '{"con_read_0",      1'b0, 1'b1, A_CON,      32'h0,        32'h0, 1'b1};

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("tx_start_reset", 32'(tx_start), 32'd0);
        check("tx_data_reset", 32'(tx_data), 32'd0);

        // Register map vectors.
        for (int i = 0; i < 11; i++) begin
            addr = vec[i].addr; wdata = vec[i].wdata; wr = vec[i].wr; rd = vec[i].rd;
            #1;
            if (vec[i].chk) check(vec[i].name, rdata, vec[i].exp);
            tick();
            wr = 1'b0; rd = 1'b0;
        end

        // Single byte: one-cycle push-to-tx_start latency, sticky done, clear on read.
        write_reg(A_CON, 32'h1);
        exp_q.push_back(8'hA5);
        write_reg(A_TXD, 32'h000000A5);
        check("tx_start_not_yet", 32'(tx_start), 32'd0);
        tick();
        check("tx_start_latency", 32'(tx_start), 32'd1);
        check("tx_data_a5", 32'(tx_data), 32'hA5);
        wait_con("tx_done_seen", 32'h4, 32'h4, 60);
        read_check("con_done_set", A_CON, 32'h5);
        peek_check("con_done_cleared", A_CON, 32'h1);

        // Full queue: the fifth byte is dropped, the rest drain in order.
        hold_busy = 1'b1;
        occ = 0;
        for (int b = 1; b <= 5; b++) begin
            if (occ < DEPTH) begin
                exp_q.push_back(8'(b));
                occ++;
            end
            write_reg(A_TXD, 32'(b));
        end
        peek_check("con_busy_held", A_CON, 32'h11);
        starts_before = n_starts;
        hold_busy = 1'b0;
        wait_con("busy_falls", 32'h10, 32'h0, 400);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("four_starts", 32'(n_starts - starts_before), 32'd4);
        peek_check("con_after_drain", A_CON, 32'h5);

        // Receive path.
        read_check("con_clear_done", A_CON, 32'h5);
        write_reg(A_CON, 32'h3);
        tick();
        rx_pulse(8'h3C);
        peek_check("rxd_3c", A_RXD, 32'h3C);
        peek_check("con_rx_ready", A_CON, 32'hB);
`ifdef UART_CTRL_IRQ_EN
        check("irq_not_yet", 32'(irq), 32'd0);
        tick();
        check("irq_rx", 32'(irq), 32'd1);
`endif
        rx_pulse(8'h77);
        peek_check("rxd_kept", A_RXD, 32'h3C);
        read_check("rxd_read", A_RXD, 32'h3C);
        peek_check("con_rx_cleared", A_CON, 32'h3);
`ifdef UART_CTRL_IRQ_EN
        check("irq_lag", 32'(irq), 32'd1);
        tick();
        check("irq_dropped", 32'(irq), 32'd0);
`endif
        rx_pulse(8'h11);
        addr = A_RXD; rd = 1'b1; rx_data = 8'h22; rx_valid = 1'b1;
        #1;
        check("rxd_same_cycle_old", rdata, 32'h11);
        tick();
        rd = 1'b0; rx_valid = 1'b0;
        peek_check("rxd_same_cycle_new", A_RXD, 32'h22);
        peek_check("con_ready_stays", A_CON, 32'hB);
        read_check("rxd_clear", A_RXD, 32'h22);
        write_reg(A_CON, 32'h1);
        rx_pulse(8'h99);
        peek_check("con_rx_disabled", A_CON, 32'h1);
        peek_check("rxd_rx_disabled", A_RXD, 32'h22);

        // Reset during WAIT with two bytes still queued.
        exp_q.push_back(8'hC1);
        write_reg(A_TXD, 32'hC1);
        write_reg(A_TXD, 32'hC2);
        write_reg(A_TXD, 32'hC3);
        peek_check("con_in_wait", A_CON, 32'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        starts_before = n_starts;
        peek_check("rxd_after_reset", A_RXD, 32'h0);
        wait_con("idle_after_reset", 32'hFFFFFFFF, 32'h0, 60);
        tick(); tick(); tick();
        peek_check("done_ignored", A_CON, 32'h0);
        write_reg(A_CON, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        check("no_start_after_reset", 32'(n_starts - starts_before), 32'd0);
        peek_check("con_flushed", A_CON, 32'h1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller between the MIPS data bus and the UART bit-level core. It decodes the UART register window and buffers outgoing bytes in a small TX queue. It sequences the core's transmitter with a start/busy/done handshake, latches received bytes, keeps the sticky status bits the CPU polls, and optionally raises an interrupt.

## Interface
- BASE_ADDR, 32'h40000018: byte address of the TXD register; RXD is at +4, CON at +8.
- TXQ_DEPTH, 4: TX queue entries; power of two, 2..16.
- sysclk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  bus byte address.
- wr  in  1  write strobe; acts at the rising edge.
- rd  in  1  read strobe; read side-effects act at the rising edge.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for the decoded register; 0 when not decoded.
- tx_data  out  8  byte presented to the core; valid while tx_start=1.
- tx_start  out  1  one-cycle pulse; the core captures tx_data.
- tx_busy  in  1  core is transmitting.
- tx_done  in  1  one-cycle pulse at the end of the core's stop bit.
- rx_data  in  8  received byte; valid with rx_valid.
- rx_valid  in  1  one-cycle pulse, byte received.
- irq  out  1  level interrupt; exists only with UART_CTRL_IRQ_EN.

## Operation
- **Register map** (word-aligned; addr[1:0] ignored):
  - TXD, write only: wdata[7:0] is pushed to the TX queue. Reads return 0.
  - RXD, read only: rdata = {24'b0, rxbuf}. A rd here clears rx_ready.
  - CON: bit[0] tx_en (RW), bit[1] rx_en (RW), bit[2] tx_done_st (R), bit[3] rx_ready (R), bit[4] tx_busy_st (R). Bits [31:5] read 0. Writes affect only bits [1:0]. A rd of CON clears tx_done_st.
- **tx_busy_st** = queue non-empty OR FSM not in IDLE OR tx_busy.
- **TX queue:**
  - Circular buffer with wrap-around pointers and a count 0..TXQ_DEPTH.
  - A push when full is silently dropped; contents and count are unchanged.
  - A push and a pop in the same cycle are both honoured, so count is unchanged.
- **TX FSM:**
  - IDLE -> START when tx_en=1, queue non-empty and tx_busy=0.
  - START: tx_start=1 and tx_data=head for exactly one cycle; the head is popped. START -> WAIT.
  - WAIT: tx_start=0. On tx_done: tx_done_st<=1, then WAIT -> IDLE.
  - Clearing tx_en never aborts a byte already started. It only blocks the next IDLE->START.
  - If a CON read and a tx_done occur in the same cycle, the set wins.
- **RX:**
  - On rx_valid with rx_en=1 and rx_ready=0: rxbuf<=rx_data and rx_ready<=1.
  - If rx_ready=1 the new byte is dropped and rxbuf is kept.
  - If an RXD read and rx_valid occur in the same cycle, the read returns the old rxbuf, the new byte is latched, and rx_ready stays 1.
  - rx_valid is ignored when rx_en=0.
- **Reset:**
  - Queue flushed, FSM to IDLE.
  - tx_start=0, tx_data=0, rxbuf=0.
  - tx_en=0, rx_en=0, tx_done_st=0, rx_ready=0, irq=0.
  - A reset in START or WAIT abandons the byte; a later tx_done from the core is ignored because the FSM is in IDLE.

## Timing
- A push at edge N makes the queue non-empty. If the FSM is idle and the core is free, it enters START at edge N+1, so tx_start is high during cycle N+1..N+2. Push-to-tx_start latency is 1 cycle.
- After tx_done at edge M, the FSM is in IDLE at M. The next tx_start can be high from M+1. The minimum gap between tx_start pulses is tx_done + 1 cycle.
- rx_valid at edge K: rx_ready and rxbuf are readable in the cycle after K.
- rdata is combinational from addr and the current state. Clear-on-read takes effect at the edge where rd=1.
- tx_start never stays high for 2 consecutive cycles.

## Configuration
- UART_CTRL_IRQ_EN defined: the irq port exists and irq = (rx_ready & rx_en) | (tx_done_st & tx_en), registered, so it is one cycle after the status change. It clears through the same clear-on-read paths.
- UART_CTRL_IRQ_EN undefined: the irq port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then read CON -> rdata=0. Write CON=3, read CON -> 32'h3.
- With tx_en=1, write TXD=8'hA5 -> tx_start high for 1 cycle with tx_data=8'hA5 one cycle after the write. Model tx_done after 20 cycles -> CON reads bit[2]=1; a second CON read shows bit[2]=0.
- Hold tx_busy=1 and write 5 bytes 8'h01..8'h05 (TXQ_DEPTH=4) -> 8'h05 dropped. Release the core -> tx_data sequence 01,02,03,04 in order, one byte per tx_done; CON bit[4] falls after the final tx_done.
- rx_en=1, rx_valid with 8'h3C -> RXD reads 8'h3C and CON bit[3]=1. A second rx_valid with 8'h77 before the read -> RXD still 8'h3C. After the RXD read, CON bit[3]=0.
- Assert reset during WAIT with 2 bytes queued -> tx_busy_st=0 and no tx_start afterwards. A tx_done then leaves tx_done_st=0.
- With UART_CTRL_IRQ_EN: rx byte arrives with rx_en=1 -> irq=1 one cycle after rx_ready. The RXD read drops irq on the following cycle.
